// File: rtl/median_line_buffer.sv
// Ring-buffer line delay: odata is idata from exactly LENGTH ce steps earlier.
// Optional MEDIAN_LB_ZERO_FILL_EN forces odata to zero until the line is full.
module median_line_buffer #(
    parameter int N      = 8,
    parameter int LENGTH = 64,
    parameter int ADDR_W = $clog2(LENGTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         ce,
    input  logic [N-1:0] idata,
    output logic [N-1:0] odata,
    output logic         ovalid,
    output logic         owrap
);

    localparam int FW = ADDR_W + 1;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LENGTH - 1);
    localparam logic [FW-1:0]     FULL = FW'(LENGTH);

    logic [N-1:0]      mem [LENGTH];
    logic [ADDR_W-1:0] wptr;
    logic [FW-1:0]     fill;
    logic              full;
    logic              wr;
    logic [N-1:0]      rd;

    assign full = (fill == FULL);
    assign wr   = ce && !rst;
    assign rd   = mem[wptr];

    // Memory carries no reset so it maps onto read-first RAM.
    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr] <= idata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr   <= '0;
            fill   <= '0;
            odata  <= '0;
            ovalid <= 1'b0;
            owrap  <= 1'b0;
        end else if (ce) begin
            wptr   <= (wptr == LAST) ? '0 : wptr + 1'b1;
            if (!full) begin
                fill <= fill + 1'b1;
            end
            ovalid <= full;
            owrap  <= (wptr == LAST);
`ifdef MEDIAN_LB_ZERO_FILL_EN
            odata  <= full ? rd : '0;
`else
            odata  <= rd;
`endif
        end else begin
            owrap  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_median_line_buffer.sv
// Randomized and directed checks of median_line_buffer (LENGTH 4 and 5)
// against a sample-history model of the line delay.
module tb_median_line_buffer;

    localparam int HMAX = 8192;

    logic       clk;
    logic       rst [2];
    logic       ce  [2];
    logic [7:0] id  [2];
    logic [7:0] od  [2];
    logic       ov  [2];
    logic       ow  [2];

    int         lenv [2];
    int         cnt  [2];
    logic [7:0] hist [2][HMAX];
    logic [7:0] eo   [2];
    logic       ev   [2];
    logic       ew   [2];
    logic       kn   [2];
    logic       init [2];
    int         total;
    int         bad;

    median_line_buffer #(.N(8), .LENGTH(4)) u4 (
        .clk(clk), .rst(rst[0]), .ce(ce[0]), .idata(id[0]),
        .odata(od[0]), .ovalid(ov[0]), .owrap(ow[0])
    );

    median_line_buffer #(.N(8), .LENGTH(5)) u5 (
        .clk(clk), .rst(rst[1]), .ce(ce[1]), .idata(id[1]),
        .odata(od[1]), .ovalid(ov[1]), .owrap(ow[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    // Expected outputs follow from the sample history since the last reset:
    // after the c-th ce edge, odata is sample c-1-LENGTH once c > LENGTH.
    task automatic model_update;
        for (int d = 0; d < 2; d++) begin
            if (rst[d]) begin
                cnt[d]  = 0;
                eo[d]   = 8'd0;
                ev[d]   = 1'b0;
                ew[d]   = 1'b0;
                kn[d]   = 1'b1;
                init[d] = 1'b1;
            end else if (ce[d]) begin
                if (cnt[d] < HMAX) hist[d][cnt[d]] = id[d];
                cnt[d]++;
                ew[d] = (cnt[d] % lenv[d]) == 0;
                if (cnt[d] > lenv[d]) begin
                    eo[d] = hist[d][cnt[d] - 1 - lenv[d]];
                    ev[d] = 1'b1;
                    kn[d] = 1'b1;
                end else begin
                    ev[d] = 1'b0;
`ifdef MEDIAN_LB_ZERO_FILL_EN
                    eo[d] = 8'd0;
                    kn[d] = 1'b1;
`else
                    kn[d] = 1'b0;
`endif
                end
            end else begin
                ew[d] = 1'b0;
            end
        end
    endtask

    task automatic compare_all;
        for (int d = 0; d < 2; d++) begin
            if (init[d]) begin
                chk($sformatf("ovalid%0d", d), 32'(ov[d]), 32'(ev[d]));
                chk($sformatf("owrap%0d", d), 32'(ow[d]), 32'(ew[d]));
                if (kn[d])
                    chk($sformatf("odata%0d", d), 32'(od[d]), 32'(eo[d]));
            end
        end
    endtask

    task automatic tick;
        @(posedge clk);
        model_update();
        @(negedge clk);
        compare_all();
    endtask

    task automatic do_reset(input int d);
        rst[d] = 1'b1;
        ce[d]  = 1'b0;
        tick();
        rst[d] = 1'b0;
    endtask

    task automatic idle_all;
        ce[0] = 1'b0;
        ce[1] = 1'b0;
    endtask

    int nhigh;
    int pulses;

    initial begin
        total   = 0;
        bad     = 0;
        lenv[0] = 4;
        lenv[1] = 5;
        for (int d = 0; d < 2; d++) begin
            init[d] = 1'b0;
            cnt[d]  = 0;
            rst[d]  = 1'b1;
            ce[d]   = 1'b0;
            id[d]   = 8'd0;
        end
        tick();
        tick();
        rst[0] = 1'b0;
        rst[1] = 1'b0;
        chk("reset_ovalid", 32'(ov[0]), 32'd0);
        chk("reset_odata", 32'(od[0]), 32'd0);
        chk("reset_owrap", 32'(ow[1]), 32'd0);

        // fill and steady state, LENGTH=4
        for (int i = 1; i <= 8; i++) begin
            ce[0] = 1'b1;
            id[0] = 8'(i);
            tick();
            if (i == 4) chk("s1_edge3_ovalid", 32'(ov[0]), 32'd0);
            if (i == 5) chk("s1_edge4_odata", 32'(od[0]), 32'd1);
            if (i == 5) chk("s1_edge4_ovalid", 32'(ov[0]), 32'd1);
            if (i == 6) chk("s1_edge5_odata", 32'(od[0]), 32'd2);
        end
        idle_all();

        // gapped ce
        do_reset(0);
        nhigh = 0;
        for (int c = 0; c < 14; c++) begin
            ce[0] = (c % 2) == 0;
            if (ce[0]) begin
                nhigh++;
                id[0] = 8'(nhigh);
            end
            tick();
            if (c == 8) chk("gap_5th_odata", 32'(od[0]), 32'd1);
            if (c == 9) chk("gap_hold_odata", 32'(od[0]), 32'd1);
            if (c == 9) chk("gap_hold_ovalid", 32'(ov[0]), 32'd1);
        end
        idle_all();

        // non-power-of-two wrap, LENGTH=5
        do_reset(1);
        pulses = 0;
        for (int i = 1; i <= 20; i++) begin
            ce[1] = 1'b1;
            id[1] = 8'(i);
            tick();
            pulses += int'(ow[1]);
            if (i == 5) chk("wrap_edge4", 32'(ow[1]), 32'd1);
            if (i == 10) chk("wrap_odata", 32'(od[1]), 32'd5);
        end
        ce[1] = 1'b0;
        tick();
        chk("wrap_pulses", 32'(pulses), 32'd4);
        chk("wrap_clear", 32'(ow[1]), 32'd0);

        // reset mid-stream
        do_reset(0);
        for (int i = 1; i <= 10; i++) begin
            ce[0] = 1'b1;
            id[0] = 8'(i);
            tick();
        end
        do_reset(0);
        for (int j = 0; j < 6; j++) begin
            ce[0] = 1'b1;
            id[0] = 8'(100 + j);
            tick();
            if (j == 3) chk("mid_ovalid_low", 32'(ov[0]), 32'd0);
            if (j == 4) chk("mid_odata", 32'(od[0]), 32'd100);
        end

        // reset together with ce
        for (int i = 0; i < 3; i++) begin
            ce[0] = 1'b1;
            id[0] = 8'(50 + i);
            tick();
        end
        rst[0] = 1'b1;
        ce[0]  = 1'b1;
        id[0]  = 8'hee;
        tick();
        rst[0] = 1'b0;
        for (int j = 1; j <= 5; j++) begin
            ce[0] = 1'b1;
            id[0] = 8'(j);
            tick();
            if (j == 4) chk("rstce_ovalid", 32'(ov[0]), 32'd0);
            if (j == 5) chk("rstce_odata", 32'(od[0]), 32'd1);
        end

        // randomized traffic on both instances
        for (int c = 0; c < 3000; c++) begin
            for (int d = 0; d < 2; d++) begin
                rst[d] = ($urandom_range(0, 199) == 0);
                ce[d]  = ($urandom_range(0, 9) < 7);
                id[d]  = 8'($urandom);
            end
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/median_line_buffer.md
# median_line_buffer

Ring-buffer line delay for the median filter pipeline. It is the read side of the pixel stream: each pixel is written into a LENGTH-deep memory on `ce`, and the pixel written exactly LENGTH `ce` steps earlier is read back from the same slot, producing the row-above tap for the 3x3 window. It sits in front of the window register array. Two instances in series give rows n-1 and n-2.

## Interface
Parameters:
- `N`, default 8: pixel width in bits.
- `LENGTH`, default 64: delay in `ce` steps, equal to the line width. Legal range is 2 to 4096.
- `ADDR_W`, default `$clog2(LENGTH)`: pointer width. Derived; do not override.

Ports:
- `clk`, input, 1: the single clock. All logic is rising-edge.
- `rst`, input, 1: synchronous, active-high reset.
- `ce`, input, 1: clock enable. One pixel advances per cycle in which `ce` is high.
- `idata`, input, N: incoming pixel.
- `odata`, output, N: pixel delayed by LENGTH `ce` steps. Registered.
- `ovalid`, output, 1: high once `odata` carries a real sample. Registered.
- `owrap`, output, 1: one-cycle pulse marking a pointer wrap. Registered.

## Operation
- State:
  - `wptr`: 0 to LENGTH-1.
  - `fill`: 0 to LENGTH, saturating.
  - Memory `mem[0:LENGTH-1]`, N bits wide. The memory is not reset.
- On a `clk` edge with `rst`=1:
  - `wptr`=0, `fill`=0.
  - `odata`=0, `ovalid`=0, `owrap`=0.
  - `rst` has priority over `ce`.
- On a `clk` edge with `ce`=1 and `rst`=0:
  - Read-before-write on the same address: `odata`<=`mem[wptr]` and `mem[wptr]`<=`idata`.
  - `wptr` advances. At LENGTH-1 it wraps to 0. It must not run to 2^ADDR_W-1 when LENGTH is not a power of two.
  - `fill`<=`fill`+1 while `fill`<LENGTH, then holds at LENGTH.
  - `ovalid`<=(`fill`==LENGTH). It therefore first rises on the edge where the LENGTH-th earlier sample is read.
  - `owrap`<=(`wptr`==LENGTH-1).
- On a `clk` edge with `ce`=0 and `rst`=0:
  - `wptr`, `fill`, `odata` and `ovalid` hold.
  - `owrap`<=0, so the pulse lasts exactly one clock.
- Reset mid-stream: all old memory contents are treated as stale. The block must refill LENGTH samples before `ovalid` rises again.
- Memory maps to distributed or block RAM. A read-first port is required.

## Timing
- Number the `ce` edges after reset k=0,1,2,…, and let s_k be `idata` sampled at edge k.
- After edge k, for k≥LENGTH: `odata`=s_(k-LENGTH) and `ovalid`=1.
- After edge k, for k<LENGTH: `ovalid`=0.
- Latency is exactly LENGTH `ce` steps, independent of `ce` gaps.
- `owrap` is high for the single cycle after edges k=LENGTH-1, 2·LENGTH-1, and so on.
- Throughput is one pixel per clock when `ce` is held high.

## Configuration
- Macro: `MEDIAN_LB_ZERO_FILL_EN`.
- Defined: while `fill`<LENGTH, `odata` is forced to 0 in place of the raw memory read. This gives zero padding on the first image line and no X values in simulation.
- Undefined: `odata` is the raw `mem[wptr]` read during fill, so it is undefined in simulation. `ovalid` behaviour is identical in both builds.

## Test plan
- Fill and steady state, with LENGTH=4, N=8, `ce`=1 and `idata`=1,2,3,…:
  - After edges 0–3: `odata`=0 and `ovalid`=0 (macro defined).
  - After edge 4: `odata`=1 and `ovalid`=1.
  - After edge 5: `odata`=2.
- Gapped `ce`, with LENGTH=4, `ce` toggling 1,0,1,0 and the same ramp:
  - `odata` and `ovalid` hold on `ce`=0 cycles.
  - `odata`=1 appears after the 5th `ce`-high edge.
- Non-power-of-two wrap, with LENGTH=5 and a 20-sample ramp:
  - `owrap` pulses after `ce` edges 4, 9, 14 and 19, for one clock each.
  - `odata` always equals the input minus 5.
- Reset mid-stream, with LENGTH=4:
  - Assert `rst` for 1 cycle after 10 samples, then send 100,101,….
  - Required: `ovalid`=0 for 4 edges, then `odata`=100.
  - Old samples 7–10 must never appear.
- Reset with `ce` in the same cycle: `rst`=1 and `ce`=1 together must give `wptr`=0 and `fill`=0, and the write must be ignored.
- Macro undefined, with LENGTH=4:
  - `ovalid` timing is identical to scenario 1.
  - `odata` is unchecked while `ovalid`=0.
  - After edge 4, `odata` is 1.
